// File: rtl/uart_hex_word_tx.sv
// uart_hex_word_tx: sends a 32-bit word as NIBBLES uppercase ASCII hex
// characters over UART 8N1, most significant nibble first.
// Optional build macro UART_HEX_CRLF_EN appends CR (0x0D) and LF (0x0A)
// after the hex characters of every word.
module uart_hex_word_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NIBBLES      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef UART_HEX_CRLF_EN
  localparam int CHARS = NIBBLES + 2;
`else
  localparam int CHARS = NIBBLES;
`endif
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        CHAR_LAST = 4'(CHARS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  // characters still to send after the one currently on the line
  logic [3:0]        char_cnt, char_cnt_n;
  // remaining nibbles, next one always in the top NIBBLES*4 position
  logic [31:0]       word_q, word_n;
  logic [7:0]        shift_q, shift_n;
  logic [7:0]        next_char;
  logic              tx_n, done_n;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  assign word_ready = (state == IDLE);
  assign busy       = !word_ready;

  // Character that follows the current one once its stop bit ends.
  always_comb begin
    next_char = hex_char(word_q[NIBBLES*4-1 -: 4]);
`ifdef UART_HEX_CRLF_EN
    if (char_cnt == 4'd2)      next_char = 8'h0D;
    else if (char_cnt == 4'd1) next_char = 8'h0A;
`endif
  end

  // Next-state, counter and serializer updates; tx is registered from the
  // next state so the start bit appears right after the accept edge.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    char_cnt_n = char_cnt;
    word_n     = word_q;
    shift_n    = shift_q;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (word_valid) begin
          state_n    = START;
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          char_cnt_n = CHAR_LAST;
          word_n     = word_in << 4;
          shift_n    = hex_char(word_in[NIBBLES*4-1 -: 4]);
        end
      end
      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            shift_n   = shift_q >> 1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_n = '0;
          if (char_cnt != 4'd0) begin
            state_n    = START;
            char_cnt_n = char_cnt - 1'b1;
            shift_n    = next_char;
            word_n     = word_q << 4;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      char_cnt <= '0;
      word_q   <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      char_cnt <= char_cnt_n;
      word_q   <= word_n;
      shift_q  <= shift_n;
      tx       <= tx_n;
      done     <= done_n;
    end
  end

endmodule
